// File: rtl/npower_ctrl_pkg.sv
// Shared nPower decode constants: primary opcodes, extended opcodes, ALU
// operation encodings and the packed control bundle carried through ID/EX.
package npower_ctrl_pkg;

    localparam logic [5:0] OP_X    = 6'd31;
    localparam logic [5:0] OP_ADDI = 6'd14;
    localparam logic [5:0] OP_ORI  = 6'd24;
    localparam logic [5:0] OP_ANDI = 6'd28;
    localparam logic [5:0] OP_LD   = 6'd58;
    localparam logic [5:0] OP_STD  = 6'd62;
    localparam logic [5:0] OP_B    = 6'd18;
    localparam logic [5:0] OP_BC   = 6'd16;

    // Extended opcodes live in instr[10:1]; XO-form ops therefore need OE = 0.
    localparam logic [9:0] XO_ADD  = 10'd266;
    localparam logic [9:0] XO_SUBF = 10'd40;
    localparam logic [9:0] XO_AND  = 10'd28;
    localparam logic [9:0] XO_OR   = 10'd444;
    localparam logic [9:0] XO_XOR  = 10'd316;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    alu_src;
        logic    branch;
        logic    mem_write;
        logic    mem_read;
        logic    mem_to_reg;
        alu_op_e alu_op;
    } ctrl_t;

    function automatic logic [63:0] sext16(input logic [15:0] v);
        return {{48{v[15]}}, v};
    endfunction

endpackage

// File: rtl/npower_decode.sv
// Combinational nPower instruction decoder: instruction word to control
// bundle, register fields, extended immediate and source-usage flags.
module npower_decode
    import npower_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic [4:0]  rt,
    output logic [4:0]  ra,
    output logic [4:0]  rb,
    output logic [63:0] imm,
    output logic        legal,
    output logic        uses_rb
);

    logic [5:0] opcode;
    logic [9:0] xo;

    assign opcode = instr[31:26];
    assign xo     = instr[10:1];
    assign rt     = instr[25:21];
    assign ra     = instr[20:16];
    assign rb     = instr[15:11];

    always_comb begin
        ctrl    = '0;
        imm     = '0;
        legal   = 1'b0;
        uses_rb = 1'b0;
        case (opcode)
            OP_X: begin
                legal          = 1'b1;
                uses_rb        = 1'b1;
                ctrl.reg_write = 1'b1;
                case (xo)
                    XO_ADD:  ctrl.alu_op = ALU_ADD;
                    XO_SUBF: ctrl.alu_op = ALU_SUB;
                    XO_AND:  ctrl.alu_op = ALU_AND;
                    XO_OR:   ctrl.alu_op = ALU_OR;
                    XO_XOR:  ctrl.alu_op = ALU_XOR;
                    default: begin
                        legal   = 1'b0;
                        uses_rb = 1'b0;
                        ctrl    = '0;
                    end
                endcase
            end
            OP_ADDI: begin
                legal          = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                imm            = sext16(instr[15:0]);
            end
            OP_ORI, OP_ANDI: begin
                legal          = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = (opcode == OP_ORI) ? ALU_OR : ALU_AND;
                imm            = {48'd0, instr[15:0]};
            end
            OP_LD: begin
                if (instr[1:0] == 2'b00) begin
                    legal           = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.alu_src    = 1'b1;
                    ctrl.mem_read   = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.alu_op     = ALU_ADD;
                    imm             = sext16({instr[15:2], 2'b00});
                end
            end
            OP_STD: begin
                if (instr[1:0] == 2'b00) begin
                    legal          = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.mem_write = 1'b1;
                    ctrl.alu_op    = ALU_ADD;
                    imm            = sext16({instr[15:2], 2'b00});
                end
            end
            OP_B: begin
                legal       = 1'b1;
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_ADD;
                imm         = {{38{instr[25]}}, instr[25:2], 2'b00};
            end
            OP_BC: begin
                legal       = 1'b1;
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
                imm         = sext16({instr[15:2], 2'b00});
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/npower_ctrl_stage.sv
// nPower decode stage with ID/EX register, load-use stall and flush.
// Optional NPOWER_ILLEGAL_TRAP_EN adds the illegal output and sticky tracking.
module npower_ctrl_stage
    import npower_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [63:0] in_pc,
    output logic        in_ready,
    input  logic        flush,
    output logic [63:0] pc,
    output logic        out_valid,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        Branch,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemtoReg,
    output logic [2:0]  ALUop,
    output logic [4:0]  rt,
    output logic [4:0]  ra,
    output logic [4:0]  rb,
    output logic [63:0] imm
`ifdef NPOWER_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    ctrl_t       dec_ctrl;
    logic [4:0]  dec_rt, dec_ra, dec_rb;
    logic [63:0] dec_imm;
    logic        dec_legal, dec_uses_rb;

    ctrl_t       ctrl_reg;
    logic        valid_reg;
    logic [63:0] pc_reg, imm_reg;
    logic [4:0]  rt_reg, ra_reg, rb_reg;

    logic load_busy, src_match, hazard, accept, load_instr;

    npower_decode u_decode (
        .instr   (in_instr),
        .ctrl    (dec_ctrl),
        .rt      (dec_rt),
        .ra      (dec_ra),
        .rb      (dec_rb),
        .imm     (dec_imm),
        .legal   (dec_legal),
        .uses_rb (dec_uses_rb)
    );

    // A load in ID/EX cannot forward to the instruction right behind it.
    assign load_busy = valid_reg & ctrl_reg.mem_read & (rt_reg != 5'd0);
    assign src_match = (dec_ra == rt_reg)
                     | (dec_uses_rb & (dec_rb == rt_reg))
                     | (dec_ctrl.mem_write & (dec_rt == rt_reg));
    assign hazard     = in_valid & dec_legal & load_busy & src_match;
    assign in_ready   = !reset & !flush & !hazard;
    assign accept     = in_valid & in_ready;
    assign load_instr = accept & dec_legal;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
            ctrl_reg  <= '0;
            pc_reg    <= '0;
            imm_reg   <= '0;
            rt_reg    <= '0;
            ra_reg    <= '0;
            rb_reg    <= '0;
        end else begin
            valid_reg <= load_instr;
            ctrl_reg  <= load_instr ? dec_ctrl : '0;
            // Bubbles keep the previous fields so EX sees stable operand indices.
            if (load_instr) begin
                pc_reg  <= in_pc;
                imm_reg <= dec_imm;
                rt_reg  <= dec_rt;
                ra_reg  <= dec_ra;
                rb_reg  <= dec_rb;
            end
        end
    end

`ifdef NPOWER_ILLEGAL_TRAP_EN
    logic illegal_reg;
    logic illegal_seen_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_reg      <= 1'b0;
            illegal_seen_reg <= 1'b0;
        end else begin
            illegal_reg      <= accept & !dec_legal;
            illegal_seen_reg <= illegal_seen_reg | (accept & !dec_legal);
        end
    end

    assign illegal = illegal_reg;
`endif

    assign out_valid = valid_reg;
    assign pc        = pc_reg;
    assign RegWrite  = ctrl_reg.reg_write;
    assign ALUSrc    = ctrl_reg.alu_src;
    assign Branch    = ctrl_reg.branch;
    assign MemWrite  = ctrl_reg.mem_write;
    assign MemRead   = ctrl_reg.mem_read;
    assign MemtoReg  = ctrl_reg.mem_to_reg;
    assign ALUop     = ctrl_reg.alu_op;
    assign rt        = rt_reg;
    assign ra        = ra_reg;
    assign rb        = rb_reg;
    assign imm       = imm_reg;

endmodule

// File: tb/tb_npower_ctrl_stage.sv
// Self-checking bench for npower_ctrl_stage: directed scenarios then a random
// instruction stream against a mnemonic-level reference model.
module tb_npower_ctrl_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic [63:0] pc;
    logic        out_valid;
    logic        RegWrite, ALUSrc, Branch, MemWrite, MemRead, MemtoReg;
    logic [2:0]  ALUop;
    logic [4:0]  rt, ra, rb;
    logic [63:0] imm;
`ifdef NPOWER_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    always #5 clk = ~clk;

    npower_ctrl_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .flush     (flush),
        .pc        (pc),
        .out_valid (out_valid),
        .RegWrite  (RegWrite),
        .ALUSrc    (ALUSrc),
        .Branch    (Branch),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .MemtoReg  (MemtoReg),
        .ALUop     (ALUop),
        .rt        (rt),
        .ra        (ra),
        .rb        (rb),
        .imm       (imm)
`ifdef NPOWER_ILLEGAL_TRAP_EN
        ,
        .illegal   (illegal)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef enum {M_NONE, M_ADD, M_SUBF, M_AND, M_OR, M_XOR, M_ADDI, M_ORI, M_ANDI,
                  M_LD, M_STD, M_B, M_BC} mnem_e;

    typedef struct {
        bit        legal;
        bit        rw, asrc, br, mw, mr, m2r;
        bit [2:0]  op;
        bit [63:0] imm;
        bit [4:0]  rt, ra, rb;
        bit        src_rb, src_rt;
    } dec_t;

    // Reference ID/EX contents
    bit        m_valid, m_rw, m_asrc, m_br, m_mw, m_mr, m_m2r, m_ill;
    bit [2:0]  m_op;
    bit [4:0]  m_rt, m_ra, m_rb;
    bit [63:0] m_imm, m_pc;

    function automatic mnem_e mnemonic(input logic [31:0] w);
        int unsigned op = w[31:26];
        int unsigned xo = w[10:1];
        case (op)
            31: case (xo)
                    266: return M_ADD;
                    40:  return M_SUBF;
                    28:  return M_AND;
                    444: return M_OR;
                    316: return M_XOR;
                    default: return M_NONE;
                endcase
            14: return M_ADDI;
            24: return M_ORI;
            28: return M_ANDI;
            58: return (w[1:0] == 2'b00) ? M_LD : M_NONE;
            62: return (w[1:0] == 2'b00) ? M_STD : M_NONE;
            18: return M_B;
            16: return M_BC;
            default: return M_NONE;
        endcase
    endfunction

    // Interpret raw as a two's-complement number of the given width.
    function automatic logic [63:0] sfield(input longint raw, input int bits);
        longint v = raw;
        if (v >= (longint'(1) <<< (bits - 1))) v = v - (longint'(1) <<< bits);
        return v;
    endfunction

    function automatic dec_t model_decode(input logic [31:0] w);
        dec_t  d;
        mnem_e m = mnemonic(w);
        d = '{default: 0};
        d.rt    = w[25:21];
        d.ra    = w[20:16];
        d.rb    = w[15:11];
        d.legal = (m != M_NONE);
        case (m)
            M_ADD:  begin d.rw = 1; d.op = 0; d.src_rb = 1; end
            M_SUBF: begin d.rw = 1; d.op = 1; d.src_rb = 1; end
            M_AND:  begin d.rw = 1; d.op = 2; d.src_rb = 1; end
            M_OR:   begin d.rw = 1; d.op = 3; d.src_rb = 1; end
            M_XOR:  begin d.rw = 1; d.op = 4; d.src_rb = 1; end
            M_ADDI: begin d.rw = 1; d.asrc = 1; d.op = 0; d.imm = sfield(longint'(w[15:0]), 16); end
            M_ORI:  begin d.rw = 1; d.asrc = 1; d.op = 3; d.imm = longint'(w[15:0]); end
            M_ANDI: begin d.rw = 1; d.asrc = 1; d.op = 2; d.imm = longint'(w[15:0]); end
            M_LD:   begin d.rw = 1; d.asrc = 1; d.mr = 1; d.m2r = 1; d.op = 0;
                          d.imm = sfield(longint'(w[15:2]) * 4, 16); end
            M_STD:  begin d.asrc = 1; d.mw = 1; d.op = 0; d.src_rt = 1;
                          d.imm = sfield(longint'(w[15:2]) * 4, 16); end
            M_B:    begin d.br = 1; d.op = 0; d.imm = sfield(longint'(w[25:2]) * 4, 26); end
            M_BC:   begin d.br = 1; d.op = 1; d.imm = sfield(longint'(w[15:2]) * 4, 16); end
            default: ;
        endcase
        return d;
    endfunction

    task automatic compare_all();
        check("out_valid", out_valid, m_valid);
        check("ctrl", {RegWrite, ALUSrc, Branch, MemWrite, MemRead, MemtoReg, ALUop},
                      {m_rw, m_asrc, m_br, m_mw, m_mr, m_m2r, m_op});
        check("rt", rt, m_rt);
        check("ra", ra, m_ra);
        check("rb", rb, m_rb);
        check("imm", imm, m_imm);
        if (m_valid) check("pc", pc, m_pc);
`ifdef NPOWER_ILLEGAL_TRAP_EN
        check("illegal", illegal, m_ill);
`endif
    endtask

    // One clock: drive at negedge, check in_ready, clock, update model, check outputs.
    task automatic cycle(input logic v, input logic [31:0] w, input logic [63:0] p,
                         input logic fl, input logic rst, output logic acc);
        dec_t d;
        bit   hz, rdy;
        in_valid = v; in_instr = w; in_pc = p; flush = fl; reset = rst;
        #1;
        d   = model_decode(w);
        hz  = v && d.legal && m_valid && m_mr && (m_rt != 0) &&
              ((d.ra == m_rt) || (d.src_rb && d.rb == m_rt) || (d.src_rt && d.rt == m_rt));
        rdy = !rst && !fl && !hz;
        check("in_ready", in_ready, rdy);
        acc = v & rdy;
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_rw = 0; m_asrc = 0; m_br = 0; m_mw = 0; m_mr = 0; m_m2r = 0;
            m_op = 0; m_rt = 0; m_ra = 0; m_rb = 0; m_imm = 0; m_pc = 0; m_ill = 0;
        end else begin
            if (acc && d.legal) begin
                m_valid = 1; m_rw = d.rw; m_asrc = d.asrc; m_br = d.br; m_mw = d.mw;
                m_mr = d.mr; m_m2r = d.m2r; m_op = d.op;
                m_rt = d.rt; m_ra = d.ra; m_rb = d.rb; m_imm = d.imm; m_pc = p;
            end else begin
                m_valid = 0; m_rw = 0; m_asrc = 0; m_br = 0; m_mw = 0; m_mr = 0; m_m2r = 0;
                m_op = 0;
            end
            m_ill = acc && !d.legal;
        end
        #1;
        compare_all();
        @(negedge clk);
    endtask

    function automatic logic [31:0] gen_instr();
        int unsigned k  = $urandom_range(0, 15);
        logic [31:0] r1 = $urandom_range(0, 3);
        logic [31:0] r2 = $urandom_range(0, 3);
        logic [31:0] r3 = $urandom_range(0, 3);
        logic [31:0] xo;
        logic [31:0] lo16 = $urandom_range(0, 65535);
        logic [31:0] ds = (lo16 & 32'hFFFC) | (($urandom_range(0, 5) == 0) ? 32'd1 : 32'd0);
        case (k)
            0, 1, 2, 3: begin
                case ($urandom_range(0, 5))
                    0: xo = 266; 1: xo = 40; 2: xo = 28; 3: xo = 444; 4: xo = 316;
                    default: xo = $urandom_range(0, 1023);
                endcase
                return (32'd31 << 26) | (r1 << 21) | (r2 << 16) | (r3 << 11) | (xo << 1) |
                       32'($urandom_range(0, 1));
            end
            4:  return (32'd14 << 26) | (r1 << 21) | (r2 << 16) | lo16;
            5:  return (32'd24 << 26) | (r1 << 21) | (r2 << 16) | lo16;
            6:  return (32'd28 << 26) | (r1 << 21) | (r2 << 16) | lo16;
            7, 8, 9: return (32'd58 << 26) | (r1 << 21) | (r2 << 16) | ds;
            10, 11: return (32'd62 << 26) | (r1 << 21) | (r2 << 16) | ds;
            12: return (32'd18 << 26) | ($urandom & 32'h03FF_FFFF);
            13: return (32'd16 << 26) | (r1 << 21) | (r2 << 16) | lo16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic        acc;
        logic [31:0] w;
        logic [63:0] p;
        bit          fl, v, rst;

        reset = 1; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1, 32'h7C611214, 64'h40, 0, 1, acc);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_pc", pc, 0);
        check("rst_imm", imm, 0);

        cycle(1, 32'h7C611214, 64'h100, 0, 0, acc);
        check("add_valid", out_valid, 1);
        check("add_regwrite", RegWrite, 1);
        check("add_aluop", ALUop, 0);
        check("add_fields", {rt, ra, rb}, {5'd3, 5'd1, 5'd2});
        check("add_pc", pc, 64'h100);

        cycle(1, 32'h3880FFFF, 64'h104, 0, 0, acc);
        check("addi_alusrc", ALUSrc, 1);
        check("addi_regwrite", RegWrite, 1);
        check("addi_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);

        cycle(1, 32'hE8A10008, 64'h108, 0, 0, acc);
        check("ld_memread", {MemRead, MemtoReg}, 2'b11);
        check("ld_imm", imm, 64'd8);
        cycle(1, 32'h7CC51214, 64'h10C, 0, 0, acc);
        check("stall_accept", acc, 0);
        check("stall_bubble", out_valid, 0);
        cycle(1, 32'h7CC51214, 64'h10C, 0, 0, acc);
        check("after_stall_valid", out_valid, 1);
        check("after_stall_rt", rt, 6);

        cycle(1, 32'h4182FFFC, 64'h110, 0, 0, acc);
        check("bc_branch", Branch, 1);
        check("bc_aluop", ALUop, 1);
        check("bc_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1, 32'h7CE11214, 64'h114, 1, 0, acc);
        check("flush_bubble", out_valid, 0);
        cycle(0, 32'h0, 64'h118, 0, 0, acc);
        check("flush_dropped", rt, 12);

        cycle(1, 32'hE8A10008, 64'h200, 0, 0, acc);
        cycle(1, 32'h7CC51214, 64'h204, 0, 1, acc);
        check("rst_stall_valid", out_valid, 0);
        check("rst_stall_ctrl", {MemRead, MemtoReg, RegWrite}, 0);
        check("rst_stall_pc", pc, 0);
        cycle(1, 32'h7CC51214, 64'h204, 0, 0, acc);
        check("post_rst_accept", acc, 1);
        check("post_rst_valid", out_valid, 1);

        cycle(1, 32'h00000000, 64'h208, 0, 0, acc);
        check("illegal_bubble", out_valid, 0);
        check("illegal_ctrl", {RegWrite, ALUSrc, Branch, MemWrite, MemRead, MemtoReg, ALUop}, 0);
`ifdef NPOWER_ILLEGAL_TRAP_EN
        check("illegal_pulse", illegal, 1);
        cycle(0, 32'h0, 64'h20C, 0, 0, acc);
        check("illegal_one_cycle", illegal, 0);
`endif

        w = gen_instr();
        p = 64'h1000;
        for (int i = 0; i < 400; i++) begin
            fl  = ($urandom_range(0, 15) == 0);
            v   = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 99) == 0);
            cycle(v, w, p, fl, rst, acc);
            if (!(v && !acc && !fl && !rst)) begin
                w = gen_instr();
                p = p + 4;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
